// File: rtl/sdram_ch2_arbiter.sv
// Round-robin arbiter sharing the SDRAM ch2 port between NREQ requesters.
// One ch2 transaction is outstanding at a time; ready/data route back to the owner.
module sdram_ch2_arbiter #(
    parameter int NREQ    = 3,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk1x,
    input  logic                 reset,
    input  logic [NREQ-1:0]      rq_req,
    input  logic [NREQ*27-1:0]   rq_addr,
    input  logic [NREQ*32-1:0]   rq_din,
    input  logic [NREQ-1:0]      rq_rnw,
    input  logic [NREQ*4-1:0]    rq_be,
    output logic [NREQ-1:0]      rq_ready,
    output logic [31:0]          rq_dout,
    output logic [NREQ-1:0]      rq_busy,
    output logic                 error_overrun,
    output logic                 error_timeout,
    output logic                 ch2_req,
    output logic [26:0]          ch2_addr,
    output logic [31:0]          ch2_din,
    output logic                 ch2_rnw,
    output logic [3:0]           ch2_be,
    input  logic                 ch2_ready,
    input  logic [31:0]          ch2_dout
);
    localparam int IW = (NREQ > 2) ? 2 : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_t;

    state_t          state;
    state_t          state_next;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   gnt;
    logic [IW-1:0]   sel;
    logic            sel_valid;
    logic [NREQ-1:0] pending;
    logic [NREQ-1:0] done_clr;
    logic [NREQ-1:0] capture;
    logic            overrun_hit;
    logic [9:0]      tmo_cnt;
    logic            finish;
    logic            timed_out;

    logic [26:0] slot_addr [NREQ];
    logic [31:0] slot_din  [NREQ];
    logic        slot_rnw  [NREQ];
    logic [3:0]  slot_be   [NREQ];

    function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) s = s - NREQ;
        return IW'(s);
    endfunction

    // Scanning downward lets the lowest offset from rr_ptr win.
    always_comb begin
        sel       = '0;
        sel_valid = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (pending[wrap_idx(rr_ptr, k)]) begin
                sel       = wrap_idx(rr_ptr, k);
                sel_valid = 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        finish     = 1'b0;
        timed_out  = 1'b0;
        case (state)
            IDLE:  if (sel_valid) state_next = ISSUE;
            ISSUE: state_next = WAIT;
            WAIT: begin
                if (ch2_ready) begin
                    finish     = 1'b1;
                    state_next = GAP;
                end else if (tmo_cnt == 10'(TIMEOUT)) begin
                    finish     = 1'b1;
                    timed_out  = 1'b1;
                    state_next = GAP;
                end
            end
            GAP:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A request landing in the completion cycle of its own slot is a fresh capture.
    assign done_clr    = finish ? (NREQ'(1) << gnt) : '0;
    assign capture     = rq_req & (~pending | done_clr);
    assign overrun_hit = |(rq_req & pending & ~done_clr);
    assign rq_busy     = pending;

    always_ff @(posedge clk1x) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk1x) begin
        if (reset) begin
            pending       <= '0;
            rr_ptr        <= '0;
            gnt           <= '0;
            tmo_cnt       <= '0;
            error_overrun <= 1'b0;
            error_timeout <= 1'b0;
            ch2_req       <= 1'b0;
            ch2_addr      <= '0;
            ch2_din       <= '0;
            ch2_rnw       <= 1'b0;
            ch2_be        <= '0;
            rq_ready      <= '0;
            rq_dout       <= '0;
            for (int i = 0; i < NREQ; i++) begin
                slot_addr[i] <= '0;
                slot_din[i]  <= '0;
                slot_rnw[i]  <= 1'b0;
                slot_be[i]   <= '0;
            end
        end else begin
            pending <= (pending & ~done_clr) | capture;
            for (int i = 0; i < NREQ; i++) begin
                if (capture[i]) begin
                    slot_addr[i] <= rq_addr[i*27 +: 27];
                    slot_din[i]  <= rq_din[i*32 +: 32];
                    slot_rnw[i]  <= rq_rnw[i];
                    slot_be[i]   <= rq_be[i*4 +: 4];
                end
            end
            if (overrun_hit) error_overrun <= 1'b1;
            if (timed_out)   error_timeout <= 1'b1;

            ch2_req <= (state_next == ISSUE);
            if (state == IDLE && sel_valid) begin
                gnt      <= sel;
                ch2_addr <= slot_addr[sel];
                ch2_din  <= slot_din[sel];
                ch2_rnw  <= slot_rnw[sel];
                ch2_be   <= slot_be[sel];
            end

            if (state == ISSUE)     tmo_cnt <= '0;
            else if (state == WAIT) tmo_cnt <= tmo_cnt + 10'd1;

            rq_ready <= done_clr;
            rq_dout  <= '0;
            if (finish) begin
                rr_ptr <= wrap_idx(gnt, 1);
                if (!timed_out && ch2_rnw) rq_dout <= ch2_dout;
            end
        end
    end
endmodule
